keypad_scanner: RTL and testbench

Drives the columns of a 4x4 matrix keypad and reads the debounced, active-low row lines. The row lines come from one debounce instance per row. The block scans one column at a time and detects a press. It emits one key code per press with a single-cycle valid strobe, then holds the column until the key is released. It sits between the per-row debounce instances and the key-consumer logic (display/entry FSM).

---
 rtl/keypad_pkg.sv | 30 +++
 rtl/keypad_key_encoder.sv | 40 ++++
 rtl/keypad_scanner.sv | 137 +++++++++++++
 tb/tb_keypad_scanner.sv | 210 +++++++++++++++++++++
 4 files changed

// File: rtl/keypad_pkg.sv
// -----------------------------------------------------------------------------
// keypad_pkg
// Shared definitions for the 4x4 matrix keypad scanner:
//   NUM_ROWS / NUM_COLS : keypad matrix dimensions
//   scan_state_e        : scanner FSM states (SCAN, HOLD)
//   HEX_MAP             : phone-layout key codes indexed by {row, col}, used
//                         when KEYPAD_SCANNER_HEX_MAP_EN is defined
// -----------------------------------------------------------------------------
package keypad_pkg;

  localparam int NUM_ROWS = 4;
  localparam int NUM_COLS = 4;

  // Two-bit encoding leaves spare codes so illegal-state recovery is
  // meaningful in the FSM.
  typedef enum logic [1:0] {
    SCAN = 2'b00,
    HOLD = 2'b01
  } scan_state_e;

  // Phone layout, row-major:
  //   row0: 1 2 3 A   row1: 4 5 6 B   row2: 7 8 9 C   row3: *(E) 0 #(F) D
  localparam logic [3:0] HEX_MAP [16] = '{
    4'h1, 4'h2, 4'h3, 4'hA,
    4'h4, 4'h5, 4'h6, 4'hB,
    4'h7, 4'h8, 4'h9, 4'hC,
    4'hE, 4'h0, 4'hF, 4'hD
  };

endpackage

// File: rtl/keypad_key_encoder.sv
// -----------------------------------------------------------------------------
// keypad_key_encoder
// Purely combinational key decode for the keypad scanner.
//   rows_n  in  [3:0] debounced row lines, 0 = conducting
//   col_idx in  [1:0] currently driven column
//   hit     out       any row is low
//   row_idx out [1:0] lowest-numbered low row (row0 has priority)
//   code    out [3:0] key code for (row_idx, col_idx)
// Build option: KEYPAD_SCANNER_HEX_MAP_EN selects the phone-layout code table;
// otherwise the code is the raw {row, col} index.
// -----------------------------------------------------------------------------
module keypad_key_encoder
  import keypad_pkg::*;
(
  input  logic [NUM_ROWS-1:0] rows_n,
  input  logic [1:0]          col_idx,
  output logic                hit,
  output logic [1:0]          row_idx,
  output logic [3:0]          code
);

  // Scan from the top row down so the lowest-indexed low row is the one
  // left in row_idx.
  always_comb begin
    hit     = ~&rows_n;
    row_idx = 2'd0;
    for (int i = NUM_ROWS - 1; i >= 0; i--) begin
      if (!rows_n[i]) begin
        row_idx = 2'(i);
      end
    end
  end

`ifdef KEYPAD_SCANNER_HEX_MAP_EN
  assign code = HEX_MAP[{row_idx, col_idx}];
`else
  assign code = {row_idx, col_idx};
`endif

endmodule

// File: rtl/keypad_scanner.sv
// -----------------------------------------------------------------------------
// keypad_scanner
// Column-scanning controller for a 4x4 matrix keypad. Drives one column low
// at a time, samples the debounced rows at the end of each column slot,
// reports one key code per press and holds the column until release.
//   clk       in        system clock
//   rst       in        asynchronous, active-low reset
//   rows_n    in  [3:0] debounced row lines, 0 = key conducting
//   cols_n    out [3:0] column drive, exactly one bit low
//   key_code  out [3:0] last detected key code
//   key_valid out       one-cycle strobe when key_code updates
//   key_held  out       high from detection until release is declared
// Parameters:
//   SCAN_DIV    cycles per column slot before rows are sampled (>= 2)
//   RELEASE_CYC consecutive all-high cycles that declare a release (>= 1)
// Build option: KEYPAD_SCANNER_HEX_MAP_EN (phone-layout codes, see encoder).
// -----------------------------------------------------------------------------
module keypad_scanner
  import keypad_pkg::*;
#(
  parameter int SCAN_DIV    = 1024,
  parameter int RELEASE_CYC = 2048
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [NUM_ROWS-1:0] rows_n,
  output logic [NUM_COLS-1:0] cols_n,
  output logic [3:0]          key_code,
  output logic                key_valid,
  output logic                key_held
);

  // One counter serves both the column slot and the release window.
  localparam int CNT_MAX = (SCAN_DIV > RELEASE_CYC) ? SCAN_DIV : RELEASE_CYC;
  localparam int CW      = (CNT_MAX > 1) ? $clog2(CNT_MAX) : 1;
  localparam logic [CW-1:0] SAMPLE_LAST  = CW'(SCAN_DIV - 1);
  localparam logic [CW-1:0] RELEASE_LAST = CW'(RELEASE_CYC - 1);

  scan_state_e   state_reg,     state_next;
  logic [1:0]    col_idx_reg,   col_idx_next;
  logic [CW-1:0] cnt_reg,       cnt_next;
  logic [3:0]    key_code_reg,  key_code_next;
  logic          key_valid_reg, key_valid_next;
  logic          key_held_reg,  key_held_next;

  logic          hit;
  logic [1:0]    row_idx;
  logic [3:0]    code;

  keypad_key_encoder u_encoder (
    .rows_n  (rows_n),
    .col_idx (col_idx_reg),
    .hit     (hit),
    .row_idx (row_idx),
    .code    (code)
  );

  // Column driver decoded straight from the registered index, so cols_n
  // changes on the same edge as col_idx and always has exactly one 0.
  generate
    for (genvar gi = 0; gi < NUM_COLS; gi++) begin : g_col_drive
      assign cols_n[gi] = (col_idx_reg != 2'(gi));
    end
  endgenerate

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_reg     <= SCAN;
      col_idx_reg   <= 2'd0;
      cnt_reg       <= '0;
      key_code_reg  <= 4'h0;
      key_valid_reg <= 1'b0;
      key_held_reg  <= 1'b0;
    end else begin
      state_reg     <= state_next;
      col_idx_reg   <= col_idx_next;
      cnt_reg       <= cnt_next;
      key_code_reg  <= key_code_next;
      key_valid_reg <= key_valid_next;
      key_held_reg  <= key_held_next;
    end
  end

  always_comb begin
    state_next     = state_reg;
    col_idx_next   = col_idx_reg;
    cnt_next       = cnt_reg;
    key_code_next  = key_code_reg;
    key_valid_next = 1'b0;          // strobe lasts exactly one cycle
    key_held_next  = key_held_reg;

    case (state_reg)
      SCAN: begin
        if (cnt_reg == SAMPLE_LAST) begin
          cnt_next = '0;
          if (hit) begin
            // Column stays put: HOLD watches the same column for release.
            key_code_next  = code;
            key_valid_next = 1'b1;
            key_held_next  = 1'b1;
            state_next     = HOLD;
          end else begin
            col_idx_next = col_idx_reg + 2'd1;
          end
        end else begin
          cnt_next = cnt_reg + CW'(1);
        end
      end

      HOLD: begin
        if (hit) begin
          // Any low row (bounce or re-press) restarts the release window.
          cnt_next = '0;
        end else if (cnt_reg == RELEASE_LAST) begin
          cnt_next      = '0;
          key_held_next = 1'b0;
          col_idx_next  = col_idx_reg + 2'd1;
          state_next    = SCAN;
        end else begin
          cnt_next = cnt_reg + CW'(1);
        end
      end

      default: begin
        state_next    = SCAN;
        col_idx_next  = 2'd0;
        cnt_next      = '0;
        key_held_next = 1'b0;
      end
    endcase
  end

  assign key_code  = key_code_reg;
  assign key_valid = key_valid_reg;
  assign key_held  = key_held_reg;

endmodule

// File: tb/tb_keypad_scanner.sv
// -----------------------------------------------------------------------------
// tb_keypad_scanner
// Self-checking bench for keypad_scanner with SCAN_DIV=4, RELEASE_CYC=8.
// Stimulus pushes the expected key code into a queue on each press; a
// monitor pops and compares whenever key_valid is seen. Expected codes are
// taken from the raw or phone-layout column of the vector table depending
// on KEYPAD_SCANNER_HEX_MAP_EN.
// -----------------------------------------------------------------------------
module tb_keypad_scanner;

  localparam int SCAN_DIV    = 4;
  localparam int RELEASE_CYC = 8;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic [3:0] rows_n = 4'hF;
  logic [3:0] cols_n;
  logic [3:0] key_code;
  logic       key_valid;
  logic       key_held;

  keypad_scanner #(
    .SCAN_DIV    (SCAN_DIV),
    .RELEASE_CYC (RELEASE_CYC)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .rows_n    (rows_n),
    .cols_n    (cols_n),
    .key_code  (key_code),
    .key_valid (key_valid),
    .key_held  (key_held)
  );

  always #5 clk = ~clk;

  int         errors = 0;
  int         checks = 0;
  logic [3:0] exp_q[$];
  logic [3:0] mon_exp;
  logic       prev_valid = 1'b0;

  typedef struct {
    logic [1:0] col;
    logic [3:0] rows;
    logic [3:0] raw;
    logic [3:0] hex;
  } vec_t;

  vec_t vecs [6] = '{
    '{2'd1, 4'b0110, 4'h1, 4'h2},   // rows 0 and 3 low: row0 wins
    '{2'd1, 4'b0111, 4'hD, 4'h0},   // row3/col1
    '{2'd0, 4'b0111, 4'hC, 4'hE},   // row3/col0
    '{2'd3, 4'b1110, 4'h3, 4'hA},   // row0/col3
    '{2'd0, 4'b1110, 4'h0, 4'h1},   // row0/col0
    '{2'd3, 4'b0111, 4'hF, 4'hD}    // row3/col3
  };

  task automatic chk(input string name, input logic [3:0] act, input logic [3:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h required %h", name, act, exp);
    end else begin
      $display("ok   %s: %h", name, act);
    end
  endtask

  function automatic logic [3:0] colpat(input logic [1:0] c);
    logic [3:0] p;
    p    = 4'hF;
    p[c] = 1'b0;
    return p;
  endfunction

  function automatic logic [3:0] pick(input vec_t v);
`ifdef KEYPAD_SCANNER_HEX_MAP_EN
    return v.hex;
`else
    return v.raw;
`endif
  endfunction

  // Monitor: every strobe must match the oldest expected code and no
  // strobe may last two cycles.
  always @(negedge clk) begin
    if (rst && key_valid) begin
      if (prev_valid) begin
        checks++;
        errors++;
        $display("FAIL key_valid_width: got 2+ cycles required 1");
      end
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_strobe: got code %h required none", key_code);
      end else begin
        mon_exp = exp_q.pop_front();
        chk("key_code", key_code, mon_exp);
      end
    end
    prev_valid = rst && key_valid;
  end

  task automatic wait_cols(input logic [3:0] target);
    int n = 0;
    while (cols_n !== target && n < 64) begin
      @(negedge clk);
      n++;
    end
    chk("wait_cols", cols_n, target);
  endtask

  task automatic wait_held(input logic lvl, input int budget);
    int n = 0;
    while (key_held !== lvl && n < budget) begin
      @(negedge clk);
      n++;
    end
    chk("wait_held", {3'b0, key_held}, {3'b0, lvl});
  endtask

  task automatic press(input vec_t v);
    wait_cols(colpat(v.col));
    rows_n = v.rows;
    exp_q.push_back(pick(v));
    wait_held(1'b1, 2 * SCAN_DIV);
    @(negedge clk);
    chk("valid_one_cycle", {3'b0, key_valid}, 4'h0);
    chk("hold_cols", cols_n, colpat(v.col));
    rows_n = 4'hF;
    wait_held(1'b0, RELEASE_CYC + 4);
    chk("release_cols", cols_n, colpat(v.col + 2'd1));
  endtask

  initial begin
    vec_t first;
    first = '{2'd2, 4'b1101, 4'h6, 4'h6};

    // Reset values
    repeat (3) @(negedge clk);
    chk("rst_cols", cols_n, 4'b1110);
    chk("rst_code", key_code, 4'h0);
    chk("rst_valid", {3'b0, key_valid}, 4'h0);
    chk("rst_held", {3'b0, key_held}, 4'h0);
    rst = 1'b1;

    // Idle rotation: four cycles per column, no strobes
    for (int i = 0; i < 16; i++) begin
      chk("rotate", cols_n, colpat(2'((i / SCAN_DIV) % 4)));
      @(negedge clk);
    end

    // Press row1 at column 2, then bounce and release
    wait_cols(colpat(first.col));
    rows_n = first.rows;
    exp_q.push_back(pick(first));
    wait_held(1'b1, 2 * SCAN_DIV);
    @(negedge clk);
    chk("valid_one_cycle", {3'b0, key_valid}, 4'h0);
    chk("held_high", {3'b0, key_held}, 4'h1);
    chk("hold_cols", cols_n, 4'b1011);
    rows_n = 4'hF;
    repeat (5) @(negedge clk);
    rows_n = 4'b1011;               // bounce on another row: no new strobe
    @(negedge clk);
    rows_n = 4'hF;
    for (int i = 1; i < RELEASE_CYC; i++) begin
      @(negedge clk);
      chk("held_window", {3'b0, key_held}, 4'h1);
    end
    @(negedge clk);
    chk("held_release", {3'b0, key_held}, 4'h0);
    chk("release_cols", cols_n, 4'b0111);

    foreach (vecs[k]) press(vecs[k]);

    // Reset in the middle of HOLD
    wait_cols(colpat(first.col));
    rows_n = first.rows;
    exp_q.push_back(pick(first));
    wait_held(1'b1, 2 * SCAN_DIV);
    @(negedge clk);
    #2 rst = 1'b0;
    #1;
    chk("midrst_cols", cols_n, 4'b1110);
    chk("midrst_held", {3'b0, key_held}, 4'h0);
    chk("midrst_valid", {3'b0, key_valid}, 4'h0);
    rows_n = 4'hF;
    @(negedge clk);
    rst = 1'b1;
    for (int i = 0; i < 8; i++) begin
      chk("restart", cols_n, colpat(2'((i / SCAN_DIV) % 4)));
      @(negedge clk);
    end

    repeat (4) @(negedge clk);
    chk("queue_empty", 4'(exp_q.size()), 4'h0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: got no finish required finish");
    $fatal(1, "timeout");
  end

endmodule
